gpio_uart_tx: RTL and testbench

- Downstream consumer of the cpu's 32-bit gpio output.
- Detects every change of gpio and queues the new value in a small FIFO.
- Serialises each queued value over a UART line as 8 uppercase ASCII hex digits plus newline.
- Gives the bench and the board a human-readable trace of program-driven gpio writes.

---
 rtl/gpio_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: watches the cpu gpio bus, queues every new value in a small
// FIFO and prints each one on a UART line as 8 uppercase hex digits + '\n'.
// Optional even-parity framing (8E1) is enabled by defining GPIO_UART_TX_PARITY_EN.
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]         CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_C = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

`ifdef GPIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // change detect + FIFO
  logic [31:0]                gpio_q;
  logic [31:0]                mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       push, accept, pop, not_empty;

  // serialiser
  state_t         state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [3:0]     char_idx, char_idx_d;
  logic [31:0]    word, word_d;
  logic [7:0]     char_byte;
  logic [3:0]     nib;
  logic           tx_d;

  assign not_empty = (count != '0);
  assign push      = (gpio != gpio_q);
  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign accept    = push && ((count != DEPTH_C) || pop);
  assign busy      = (state != IDLE) || not_empty;

  // history register, FIFO pointers/occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      gpio_q <= gpio;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while count says empty
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= gpio;
  end

  // current character: the word is shifted left a nibble per character sent
  always_comb begin
    nib       = word[31:28];
    char_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    if (char_idx == 4'd8) char_byte = 8'h0A;
  end

  // next-state logic for the UART framer
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    char_idx_d = char_idx;
    word_d     = word;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop        = 1'b1;
          word_d     = mem[rd_ptr];
          char_idx_d = '0;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else cnt_d = cnt + 1'b1;
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef GPIO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_idx_d = bit_idx + 1'b1;
        end else cnt_d = cnt + 1'b1;
      end
`ifdef GPIO_UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_MAX) begin
          cnt_d   = '0;
          state_d = STOP;
        end else cnt_d = cnt + 1'b1;
      end
`endif
      STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_d = '0;
          if (char_idx < 4'd8) begin
            char_idx_d = char_idx + 1'b1;
            word_d     = {word[27:0], 4'h0};
            state_d    = START;
          end else state_d = IDLE;
        end else cnt_d = cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the state being entered, so the start bit leaves
  // on the same edge as the pop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = char_byte[bit_idx_d];
`ifdef GPIO_UART_TX_PARITY_EN
      PARITY: tx_d = ^char_byte;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // framer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word     <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      char_idx <= char_idx_d;
      word     <= word_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx (CLKS_PER_BIT=4, depth 4) with a byte
// scoreboard fed when gpio is driven and drained by a tx line decoder.
module tb_gpio_uart_tx;

  localparam int CPB = 4;
`ifdef GPIO_UART_TX_PARITY_EN
  localparam int CHAR_CYC = 11 * CPB;
`else
  localparam int CHAR_CYC = 10 * CPB;
`endif
  localparam int WORD_CYC = 9 * CHAR_CYC;

  logic        clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic [31:0] gpio = '0;
  logic        tx, busy, overflow;
  int          cyc = 0;
  int          n_assert = 0, n_fail = 0;
  logic [7:0]  exp_q [$];
  string       hexs = "0123456789ABCDEF";

  gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .gpio(gpio), .tx(tx), .busy(busy), .overflow(overflow)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexs[w[i*4 +: 4]]);
    exp_q.push_back(8'h0A);
  endtask

  // decode one character; st = cycle at which the start bit was first seen
  task automatic rx_byte(output logic [7:0] b, output int st, output bit ok);
    int t = 0;
    b = '0; st = 0; ok = 1'b0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) begin
      check("rx_start_timeout", tx, 1'b0);
      return;
    end
    st = cyc;
    wait_neg(CPB / 2);
    check("start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_neg(CPB);
      b[i] = tx;
    end
`ifdef GPIO_UART_TX_PARITY_EN
    wait_neg(CPB);
    check("parity_bit", tx, ^b);
`endif
    wait_neg(CPB);
    check("stop_bit", tx, 1'b1);
    ok = 1'b1;
  endtask

  task automatic rx_word(output int st);
    logic [7:0] b;
    int s;
    bit ok;
    st = 0;
    for (int c = 0; c < 9; c++) begin
      rx_byte(b, s, ok);
      if (!ok) return;
      if (c == 0) st = s;
      if (exp_q.size() == 0) check("unexpected_char", b, 8'hxx);
      else check($sformatf("char%0d", c), b, exp_q.pop_front());
    end
  endtask

  initial begin
    int c0, s, zeros;
    int ws [5];
    logic [31:0] vals [6];
    vals = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h89AB_CDEF,
             32'h0000_0001, 32'hA5A5_A5A5, 32'h1357_9BDF};

    // 1: reset with the clock stopped, then with it running
    #3 rst = 1'b1;
    #1;
    check("rst_stopped_tx", tx, 1'b1);
    check("rst_stopped_busy", busy, 1'b0);
    check("rst_stopped_ovf", overflow, 1'b0);
    clk_en = 1'b1;
    wait_neg(3);
    check("rst_running_tx", tx, 1'b1);
    check("rst_running_busy", busy, 1'b0);
    rst = 1'b0;
    wait_neg(5);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);

    // 2: single word 0x2A, latency and exact word length
    c0 = cyc;
    gpio = 32'h0000_002A;
    push_word(gpio);
    rx_word(s);
    check("latency_2a", s - c0, 2);
    while (cyc < s + WORD_CYC - 1) @(negedge clk);
    check("busy_last_stop", busy, 1'b1);
    @(negedge clk);
    check("busy_after_word", busy, 1'b0);
    check("ovf_after_2a", overflow, 1'b0);
    check("queue_empty_2a", exp_q.size(), 0);

    // 3: constant gpio reports exactly once
    gpio = 32'h1234_5678;
    push_word(gpio);
    rx_word(s);
    zeros = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("hold_no_restart", zeros, 0);
    check("hold_busy", busy, 1'b0);

    // 4: six changes in six cycles; depth 4 plus the first pop keeps five
    for (int i = 0; i < 5; i++) push_word(vals[i]);
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          gpio = vals[i];
          @(negedge clk);
        end
        check("ovf_set", overflow, 1'b1);
      end
      begin
        for (int w = 0; w < 5; w++) rx_word(ws[w]);
      end
    join
    check("latency_burst", ws[0] - c0, 2);
    for (int w = 1; w < 5; w++) check($sformatf("word_gap%0d", w), ws[w] - ws[w-1], WORD_CYC + 1);
    wait_neg(CPB);
    check("queue_empty_burst", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1'b1);
    check("burst_busy", busy, 1'b0);

    // 5: reset in the middle of the 4th character, then full re-report
    gpio = 32'hDEAD_BEEF;
    push_word(gpio);
    fork
      begin
        logic [7:0] b;
        bit ok;
        for (int c = 0; c < 3; c++) begin
          rx_byte(b, s, ok);
          if (c == 0) c0 = s;
          if (exp_q.size() != 0) check($sformatf("pre_rst_char%0d", c), b, exp_q.pop_front());
        end
      end
    join
    while (cyc < c0 + 3 * CHAR_CYC + CHAR_CYC / 2) @(negedge clk);
    check("mid_char_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ovf", overflow, 1'b0);
    exp_q.delete();
    push_word(gpio);
    wait_neg(2);
    c0 = cyc;
    rst = 1'b0;
    rx_word(s);
    check("latency_rerun", s - c0, 2);
    wait_neg(CPB);
    check("final_busy", busy, 1'b0);
    check("final_ovf", overflow, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
